// File: rtl/bch_encode_pkg.sv
// Shared BCH definitions: FSM state type, the n2m field-size helper and the
// generator polynomial lookup used by bch_encode.
package bch_encode_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } enc_state_t;

    localparam int GEN_MAX = 64;

    // Smallest M with 2^M - 1 >= n; equals log2(n + 1) for a valid code length.
    function automatic int n2m(input int n);
        int m;
        int p;
        m = 32'sd0;
        p = 32'sd1;
        while ((p - 32'sd1) < n) begin
            p = p * 32'sd2;
            m = m + 32'sd1;
        end
        return m;
    endfunction

    // Generator polynomial g(x) of the primitive narrow-sense BCH code (N, T),
    // bit i holding the x^i coefficient.
    function automatic logic [GEN_MAX-1:0] bch_generator(input int n, input int t);
        logic [GEN_MAX-1:0] g;
        g = {GEN_MAX{1'b0}};
        case (n)
            32'sd7: begin
                case (t)
                    32'sd1:  g = 64'h0000_0000_0000_000B;
                    default: g = {GEN_MAX{1'b0}};
                endcase
            end
            32'sd15: begin
                case (t)
                    32'sd1:  g = 64'h0000_0000_0000_0013;
                    32'sd2:  g = 64'h0000_0000_0000_01D1;
                    32'sd3:  g = 64'h0000_0000_0000_0537;
                    default: g = {GEN_MAX{1'b0}};
                endcase
            end
            32'sd31: begin
                case (t)
                    32'sd1:  g = 64'h0000_0000_0000_0025;
                    32'sd2:  g = 64'h0000_0000_0000_0769;
                    default: g = {GEN_MAX{1'b0}};
                endcase
            end
            default: g = {GEN_MAX{1'b0}};
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bch_encode_lfsr_div.sv
// Division LFSR for the systematic BCH encoder: accumulates the remainder of
// m(x)*x^W mod g(x) while message bits stream in, then shifts it out MSB first.
module bch_lfsr_div #(
    parameter int             W    = 10,
    parameter logic [W-1:0]   POLY = {W{1'b0}}
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic shift,
    input  logic feedback_en,
    input  logic bit_in,
    output logic msb
);

    logic [W-1:0] lfsr;
    logic [W-1:0] base;
    logic         fb;

    // A load starts a new division from an all-zero register in the same step.
    always_comb begin
        base = load ? {W{1'b0}} : lfsr;
        fb   = feedback_en & (bit_in ^ base[W-1]);
    end

    // Remainder register: shift with optional g(x) feedback, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= {W{1'b0}};
        end else if (shift) begin
            lfsr <= {base[W-2:0], 1'b0} ^ (fb ? POLY : {W{1'b0}});
        end else begin
            lfsr <= lfsr;
        end
    end

    assign msb = lfsr[W-1];

endmodule

// File: rtl/bch_encode.sv
// Serial systematic BCH encoder: K message bits pass through, then N-K parity
// bits follow. Optional BCH_ENCODE_MARKERS_EN adds first_out/last_out markers.
module bch_encode
    import bch_encode_pkg::*;
#(
    parameter int N = 15,
    parameter int K = 5,
    parameter int T = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic data_in,
    output logic busy,
    output logic output_valid,
    output logic data_out
`ifdef BCH_ENCODE_MARKERS_EN
    ,
    output logic first_out,
    output logic last_out
`endif
);

    localparam int         M = n2m(N);
    localparam int         P = N - K;
    localparam logic [P:0] G = (P + 1)'(bch_generator(N, T));

    enc_state_t     state;
    logic [M-1:0]   cnt;
    logic           accept;
    logic           shift;
    logic           feedback_en;
    logic           load;
    logic           msb;

    assign accept = start & ~busy;

    // LFSR control: feedback only while message bits are entering.
    always_comb begin
        shift       = 1'b0;
        feedback_en = 1'b0;
        load        = 1'b0;
        case (state)
            IDLE: begin
                shift       = accept;
                feedback_en = accept;
                load        = accept;
            end
            DATA: begin
                shift       = 1'b1;
                feedback_en = 1'b1;
            end
            PARITY: begin
                shift       = 1'b1;
            end
            default: begin
                shift       = 1'b0;
            end
        endcase
    end

    bch_lfsr_div #(
        .W    (P),
        .POLY (G[P-1:0])
    ) u_lfsr (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .shift       (shift),
        .feedback_en (feedback_en),
        .bit_in      (data_in),
        .msb         (msb)
    );

    // Codeword sequencing; busy drops during the last parity cycle so a new
    // start can follow without a gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= {M{1'b0}};
            busy         <= 1'b0;
            output_valid <= 1'b0;
            data_out     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state        <= DATA;
                        cnt          <= M'(1);
                        busy         <= 1'b1;
                        output_valid <= 1'b1;
                        data_out     <= data_in;
                    end else begin
                        output_valid <= 1'b0;
                        data_out     <= 1'b0;
                    end
                end
                DATA: begin
                    data_out <= data_in;
                    if (cnt == M'(K - 1)) begin
                        state <= PARITY;
                        cnt   <= {M{1'b0}};
                    end else begin
                        cnt   <= cnt + M'(1);
                    end
                end
                PARITY: begin
                    data_out <= msb;
                    if (cnt == M'(P - 1)) begin
                        state <= IDLE;
                        cnt   <= {M{1'b0}};
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= cnt + M'(1);
                    end
                end
                default: begin
                    state        <= IDLE;
                    cnt          <= {M{1'b0}};
                    busy         <= 1'b0;
                    output_valid <= 1'b0;
                    data_out     <= 1'b0;
                end
            endcase
        end
    end

`ifdef BCH_ENCODE_MARKERS_EN
    // Boundary markers registered alongside data_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_out <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            first_out <= accept;
            last_out  <= (state == PARITY) && (cnt == M'(P - 1));
        end
    end
`endif

endmodule

// File: tb/tb_bch_encode.sv
// Self-checking bench for bch_encode (15,5,3): expected codewords come from
// polynomial long division of m(x)*x^10 by g(x), scheduled on a cycle timeline.
module tb_bch_encode;

    localparam int MAXC = 2048;
    localparam logic [10:0] GPOLY = 11'b101_0011_0111;

    logic clk;
    logic reset;
    logic start;
    logic data_in;
    logic busy;
    logic output_valid;
    logic data_out;
`ifdef BCH_ENCODE_MARKERS_EN
    logic first_out;
    logic last_out;
    logic exp_f [0:MAXC-1];
    logic exp_l [0:MAXC-1];
`endif

    logic exp_v [0:MAXC-1];
    logic exp_b [0:MAXC-1];
    logic exp_d [0:MAXC-1];

    int total;
    int bad;
    int cyc;

    bch_encode #(.N(15), .K(5), .T(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .data_in      (data_in),
        .busy         (busy),
        .output_valid (output_valid),
        .data_out     (data_out)
`ifdef BCH_ENCODE_MARKERS_EN
        ,
        .first_out    (first_out),
        .last_out     (last_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Systematic codeword: message in the top 5 bits, remainder below.
    function automatic logic [14:0] ref_cw(input logic [4:0] msg);
        logic [14:0] r;
        logic [14:0] g;
        r = {msg, 10'b0};
        g = {4'b0, GPOLY};
        for (int d = 14; d >= 10; d--) begin
            if (r[d]) r = r ^ (g << (d - 10));
        end
        return {msg, r[9:0]};
    endfunction

    task automatic clear_from(input int c0);
        for (int c = c0; c < MAXC; c++) begin
            exp_v[c] = 1'b0;
            exp_b[c] = 1'b0;
            exp_d[c] = 1'b0;
`ifdef BCH_ENCODE_MARKERS_EN
            exp_f[c] = 1'b0;
            exp_l[c] = 1'b0;
`endif
        end
    endtask

    task automatic check_cycle();
        total++;
        assert (output_valid === exp_v[cyc]) else begin
            bad++;
            $error("FAIL valid cyc=%0d observed=%b expected=%b", cyc, output_valid, exp_v[cyc]);
        end
        total++;
        assert (busy === exp_b[cyc]) else begin
            bad++;
            $error("FAIL busy cyc=%0d observed=%b expected=%b", cyc, busy, exp_b[cyc]);
        end
        if (exp_v[cyc]) begin
            total++;
            assert (data_out === exp_d[cyc]) else begin
                bad++;
                $error("FAIL data cyc=%0d observed=%b expected=%b", cyc, data_out, exp_d[cyc]);
            end
        end
`ifdef BCH_ENCODE_MARKERS_EN
        total++;
        assert (first_out === exp_f[cyc]) else begin
            bad++;
            $error("FAIL first cyc=%0d observed=%b expected=%b", cyc, first_out, exp_f[cyc]);
        end
        total++;
        assert (last_out === exp_l[cyc]) else begin
            bad++;
            $error("FAIL last cyc=%0d observed=%b expected=%b", cyc, last_out, exp_l[cyc]);
        end
`endif
    endtask

    task automatic tick(input logic s, input logic d);
        start   = s;
        data_in = d;
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Idle cycles with random data; optionally poke start while busy.
    task automatic idle(input int n, input bit noisy);
        for (int i = 0; i < n; i++) begin
            tick(noisy && exp_b[cyc] && ($urandom_range(0, 3) == 0), 1'($urandom));
        end
    endtask

    task automatic send(input logic [4:0] msg);
        logic [14:0] cw;
        cw = ref_cw(msg);
        for (int j = 0; j < 15; j++) begin
            exp_v[cyc + 1 + j] = 1'b1;
            exp_d[cyc + 1 + j] = cw[14 - j];
        end
        for (int j = 1; j < 15; j++) exp_b[cyc + j] = 1'b1;
`ifdef BCH_ENCODE_MARKERS_EN
        exp_f[cyc + 1]  = 1'b1;
        exp_l[cyc + 15] = 1'b1;
`endif
        for (int i = 0; i < 5; i++) tick(i == 0, msg[4 - i]);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        reset   = 1'b1;
        start   = 1'b0;
        data_in = 1'b0;
        clear_from(0);

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_cycle();
        total++;
        assert (data_out === 1'b0) else begin
            bad++;
            $error("FAIL reset_data observed=%b expected=%b", data_out, 1'b0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Zero message, g(x) itself, all ones (gaps between codewords)
        send(5'b00000);
        idle(11, 1'b0);
        send(5'b00001);
        idle(11, 1'b0);
        send(5'b11111);
        idle(11, 1'b0);

        // Back-to-back with an ignored start in cycle 7 of the first codeword
        send(5'b10110);
        idle(2, 1'b0);
        tick(1'b1, 1'b1);
        idle(7, 1'b0);
        send(5'b01101);
        idle(12, 1'b0);

        // Reset mid-codeword (cycle 8), then a clean restart
        send(5'b00001);
        idle(3, 1'b0);
        reset = 1'b1;
        clear_from(cyc);
        @(negedge clk);
        check_cycle();
        total++;
        assert (data_out === 1'b0) else begin
            bad++;
            $error("FAIL midreset_data observed=%b expected=%b", data_out, 1'b0);
        end
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
        idle(2, 1'b0);
        send(5'b00001);
        idle(12, 1'b0);

        // Random messages, random gaps (gap 0 is back-to-back), noisy starts
        for (int r = 0; r < 40; r++) begin
            send(5'($urandom));
            idle(10 + $urandom_range(0, 3), 1'b1);
        end
        idle(16, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
